// File: rtl/sync_pkg.sv
// Shared limits and helpers for the multi-stage synchroniser/filter family.
// Contents: parameter limits and a constant-function clog2 that never returns 0.
package sync_pkg;

  localparam int unsigned WIDTH_MAX    = 32;
  localparam int unsigned STAGES_MIN   = 2;
  localparam int unsigned STAGES_MAX   = 4;
  localparam int unsigned FILT_CNT_MAX = 255;

  // ceil(log2(val)), at least 1 so a zero-length filter still has a legal counter vector.
  function automatic int unsigned clog2_min1(input int unsigned val);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(val)) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_nstage_filt_if.sv
// Channel bundle for sync_nstage_filt.
//   data_in  : asynchronous level inputs (driven by master)
//   data_out : synchronised, filtered levels
//   rise     : one-cycle 0->1 pulse per channel
//   fall     : one-cycle 1->0 pulse per channel
//   chg      : any rise or fall this cycle
interface sync_nstage_filt_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             chg;

  modport master (output data_in, input data_out, input rise, input fall, input chg);
  modport slave  (input data_in, output data_out, output rise, output fall, output chg);
endinterface

// File: rtl/sync_bit_filt.sv
// One channel: STAGES-deep synchroniser chain, stability counter, filtered level and
// registered edge pulses.
//   clk, rst_n : clock, synchronous active-low reset
//   data_in    : asynchronous level
//   data_out   : filtered level (filt register)
//   rise, fall : one-cycle pulses coincident with the first cycle data_out shows the new level
module sync_bit_filt
  import sync_pkg::*;
#(
  parameter int unsigned STAGES   = 2,
  parameter int unsigned FILT_CNT = 0,
  parameter logic        RST_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic data_in,
  output logic data_out,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = clog2_min1(FILT_CNT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(FILT_CNT);

  logic [STAGES-1:0] stage_q;
  logic [CntW-1:0]   cnt_q;
  logic              filt_q;
  logic              rise_q;
  logic              fall_q;
  logic              s;

  assign s = stage_q[STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q <= {STAGES{RST_VAL}};
      cnt_q   <= '0;
      filt_q  <= RST_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], data_in};
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      if (s == filt_q) begin
        // Any return to the current level discards the partial count.
        cnt_q <= '0;
      end else if (cnt_q == CntMax) begin
        filt_q <= s;
        cnt_q  <= '0;
        rise_q <= s;
        fall_q <= ~s;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign data_out = filt_q;
  assign rise     = rise_q;
  assign fall     = fall_q;

endmodule

// File: rtl/sync_nstage_filt.sv
// WIDTH independent synchroniser/glitch-filter channels with edge pulses.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of sync_nstage_filt_if (data_in in; data_out/rise/fall/chg out)
// All outputs come straight from registers; chg is an OR of registered pulses.
module sync_nstage_filt
  import sync_pkg::*;
#(
  parameter int unsigned      WIDTH    = 1,
  parameter int unsigned      STAGES   = 2,
  parameter int unsigned      FILT_CNT = 0,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  sync_nstage_filt_if.slave   bus
);

  if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("sync_nstage_filt: WIDTH %0d out of range 1..%0d", WIDTH, WIDTH_MAX);
  end
  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("sync_nstage_filt: STAGES %0d out of range %0d..%0d", STAGES, STAGES_MIN,
           STAGES_MAX);
  end
  if (FILT_CNT > FILT_CNT_MAX) begin : g_bad_filt
    $error("sync_nstage_filt: FILT_CNT %0d exceeds %0d", FILT_CNT, FILT_CNT_MAX);
  end

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_ch
    sync_bit_filt #(
      .STAGES   (STAGES),
      .FILT_CNT (FILT_CNT),
      .RST_VAL  (RST_VAL[i])
    ) u_bit (
      .clk      (clk),
      .rst_n    (rst_n),
      .data_in  (bus.data_in[i]),
      .data_out (bus.data_out[i]),
      .rise     (bus.rise[i]),
      .fall     (bus.fall[i])
    );
  end

  assign bus.chg = |(bus.rise | bus.fall);

endmodule

// File: tb/tb_sync_nstage_filt.sv
module tb_sync_nstage_filt;

  // Four configurations: k0 W1/S2/F0, k1 W4/S3/F4, k2 W8/S2/F1, k3 W8/S2/F2/RST_VAL=FF
  localparam int PW [4] = '{1, 4, 8, 8};
  localparam int PS [4] = '{2, 3, 2, 2};
  localparam int PF [4] = '{0, 4, 1, 2};
  localparam logic [7:0] PRV [4] = '{8'h00, 8'h00, 8'h00, 8'hFF};

  logic clk;
  logic rst_n;

  sync_nstage_filt_if #(.WIDTH(1)) bus0 ();
  sync_nstage_filt_if #(.WIDTH(4)) bus1 ();
  sync_nstage_filt_if #(.WIDTH(8)) bus2 ();
  sync_nstage_filt_if #(.WIDTH(8)) bus3 ();

  sync_nstage_filt #(.WIDTH(1), .STAGES(2), .FILT_CNT(0), .RST_VAL(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  sync_nstage_filt #(.WIDTH(4), .STAGES(3), .FILT_CNT(4), .RST_VAL(4'h0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  sync_nstage_filt #(.WIDTH(8), .STAGES(2), .FILT_CNT(1), .RST_VAL(8'h00)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));
  sync_nstage_filt #(.WIDTH(8), .STAGES(2), .FILT_CNT(2), .RST_VAL(8'hFF)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Stimulus values applied on the next step
  logic       rn;
  logic [7:0] v0, v1, v2, v3;

  // Reference model state
  logic [7:0] m_pipe [4][4];
  logic [7:0] m_filt [4];
  int         m_cnt  [4][8];
  logic [7:0] m_rise [4];
  logic [7:0] m_fall [4];

  typedef struct {
    int         k;
    logic [7:0] out;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       chg;
  } exp_t;
  exp_t sb [$];

  typedef struct {
    logic rst;
    logic din;
    logic out;
    logic rise;
    logic fall;
    logic chg;
  } vec_t;
  vec_t tbl [22];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic model_edge(input int k, input logic [7:0] din, input logic rstn);
    logic [7:0] s;
    if (!rstn) begin
      for (int j = 0; j < 4; j++) m_pipe[k][j] = PRV[k];
      m_filt[k] = PRV[k];
      for (int b = 0; b < 8; b++) m_cnt[k][b] = 0;
      m_rise[k] = 8'h00;
      m_fall[k] = 8'h00;
    end else begin
      s = m_pipe[k][PS[k]-1];
      m_rise[k] = 8'h00;
      m_fall[k] = 8'h00;
      for (int b = 0; b < PW[k]; b++) begin
        if (s[b] == m_filt[k][b]) begin
          m_cnt[k][b] = 0;
        end else if (m_cnt[k][b] == PF[k]) begin
          m_filt[k][b] = s[b];
          m_cnt[k][b]  = 0;
          if (s[b]) m_rise[k][b] = 1'b1;
          else      m_fall[k][b] = 1'b1;
        end else begin
          m_cnt[k][b] = m_cnt[k][b] + 1;
        end
      end
      for (int j = 3; j > 0; j--) m_pipe[k][j] = m_pipe[k][j-1];
      m_pipe[k][0] = din;
    end
  endtask

  task automatic get_act(input int k, output logic [7:0] o, output logic [7:0] r,
                         output logic [7:0] f, output logic c);
    case (k)
      0: begin o = {7'b0, bus0.data_out}; r = {7'b0, bus0.rise}; f = {7'b0, bus0.fall};
               c = bus0.chg; end
      1: begin o = {4'b0, bus1.data_out}; r = {4'b0, bus1.rise}; f = {4'b0, bus1.fall};
               c = bus1.chg; end
      2: begin o = bus2.data_out; r = bus2.rise; f = bus2.fall; c = bus2.chg; end
      default: begin o = bus3.data_out; r = bus3.rise; f = bus3.fall; c = bus3.chg; end
    endcase
  endtask

  // One clock: drive on negedge, update model at posedge, compare 1 time unit later.
  task automatic step();
    exp_t e;
    logic [7:0] o, r, f;
    logic c;
    logic [7:0] dv [4];
    dv[0] = v0; dv[1] = v1; dv[2] = v2; dv[3] = v3;
    @(negedge clk);
    rst_n        = rn;
    bus0.data_in = v0[0];
    bus1.data_in = v1[3:0];
    bus2.data_in = v2;
    bus3.data_in = v3;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      model_edge(k, dv[k], rn);
      e.k    = k;
      e.out  = m_filt[k];
      e.rise = m_rise[k];
      e.fall = m_fall[k];
      e.chg  = |(m_rise[k] | m_fall[k]);
      sb.push_back(e);
    end
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      get_act(e.k, o, r, f, c);
      total++;
      if ({o, r, f, c} !== {e.out, e.rise, e.fall, e.chg} || (r & f) != 8'h00) begin
        bad++;
        $display("FAIL sb_inst%0d cyc=%0d got out=%h rise=%h fall=%h chg=%b expected out=%h rise=%h fall=%h chg=%b",
                 e.k, cyc, o, r, f, c, e.out, e.rise, e.fall, e.chg);
      end
    end
    cyc++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int hold [4];
    int nchg;

    //            rst din out rise fall chg
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[20] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[21] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    bus0.data_in = '0; bus1.data_in = '0; bus2.data_in = '0; bus3.data_in = '0;
    rn = 1'b0; v0 = '0; v1 = '0; v2 = '0; v3 = '0;
    step(); step();
    chk("reset_k3_out", 32'(bus3.data_out), 32'hFF);
    chk("reset_k1_out", 32'(bus1.data_out), 32'h0);

    // k0 (FILT_CNT=0): latency, pulses, 1-cycle glitch pass-through, reset mid-pulse
    for (int i = 0; i < 22; i++) begin
      rn = tbl[i].rst;
      v0 = {7'b0, tbl[i].din};
      step();
      chk($sformatf("tbl_row%0d", i),
          32'({bus0.data_out, bus0.rise, bus0.fall, bus0.chg}),
          32'({tbl[i].out, tbl[i].rise, tbl[i].fall, tbl[i].chg}));
    end
    v0 = '0;
    rn = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // k1 bit0: 4-cycle pulse must be rejected
    for (int i = 1; i <= 14; i++) begin
      v1 = (i <= 4) ? 8'h01 : 8'h00;
      step();
      chk($sformatf("glitch4_step%0d", i),
          32'({bus1.data_out, bus1.rise, bus1.fall}), 32'h0);
    end
    // k1 bit0: 5-cycle pulse passes after STAGES+FILT_CNT+1 = 8 edges
    for (int i = 1; i <= 22; i++) begin
      v1 = (i <= 5) ? 8'h01 : 8'h00;
      step();
      if (i == 7) chk("hold5_e7_out", 32'(bus1.data_out), 32'h0);
      if (i == 8) chk("hold5_e8_out_rise", 32'({bus1.data_out, bus1.rise}), 32'({4'h1, 4'h1}));
      if (i == 9) chk("hold5_e9_rise", 32'({bus1.data_out, bus1.rise}), 32'({4'h1, 4'h0}));
    end

    // k1: reset while cnt = FILT_CNT-1, then full latency after release
    v1 = 8'h01;
    for (int i = 0; i < 6; i++) step();
    rn = 1'b0;
    step();
    chk("rst_midfilt", 32'({bus1.data_out, bus1.rise, bus1.fall, bus1.chg}), 32'h0);
    rn = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      if (i == 7) chk("rst_midfilt_e7", 32'(bus1.data_out), 32'h0);
      if (i == 8) chk("rst_midfilt_e8", 32'({bus1.data_out, bus1.rise}), 32'({4'h1, 4'h1}));
    end
    v1 = 8'h00;
    for (int i = 0; i < 10; i++) step();

    // k2: 0x00 -> 0xA5, latency 4, single chg cycle
    nchg = 0;
    v2 = 8'hA5;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (bus2.chg) nchg++;
      if (i == 3) chk("a5_e3_out", 32'(bus2.data_out), 32'h00);
      if (i == 4) chk("a5_e4_pulse", 32'({bus2.data_out, bus2.rise, bus2.fall, 7'b0, bus2.chg}),
                      32'({8'hA5, 8'hA5, 8'h00, 8'h01}));
      if (i == 5) chk("a5_e5_rise", 32'(bus2.rise), 32'h00);
    end
    chk("a5_chg_cycles", 32'(nchg), 32'd1);
    // Simultaneous rising and falling channels
    v2 = 8'h5A;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i == 4) chk("5a_pulses", 32'({bus2.rise, bus2.fall}), 32'({8'h5A, 8'hA5}));
    end

    // k3: RST_VAL=FF with data_in=0, then fall after 5 edges
    v3 = 8'h00;
    rn = 1'b0;
    step();
    chk("ff_in_reset", 32'({bus3.data_out, bus3.rise, bus3.fall}), 32'({8'hFF, 8'h00, 8'h00}));
    step();
    rn = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 4) chk("ff_rel_e4", 32'({bus3.data_out, bus3.fall}), 32'({8'hFF, 8'h00}));
      if (i == 5) chk("ff_rel_e5", 32'({bus3.data_out, bus3.fall, 7'b0, bus3.chg}),
                      32'({8'h00, 8'hFF, 8'h01}));
      if (i == 6) chk("ff_rel_e6", 32'(bus3.fall), 32'h00);
    end

    // Random glitch widths; the scoreboard checks every cycle
    for (int b = 0; b < 4; b++) hold[b] = 0;
    for (int n = 0; n < 500; n++) begin
      for (int b = 0; b < 4; b++) begin
        if (hold[b] == 0) begin
          v1[b]   = 1'($urandom_range(0, 1));
          hold[b] = int'($urandom_range(1, 7));
        end
        hold[b] = hold[b] - 1;
      end
      if ($urandom_range(0, 2) == 0) v0 = 8'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) v2 = 8'($urandom);
      if ($urandom_range(0, 4) == 0) v3 = 8'($urandom);
      rn = ($urandom_range(0, 59) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_nstage_filt.md
SYNC_NSTAGE_FILT -- requirements
Module: sync_nstage_filt

Interface
REQ-001 SHALL have parameter WIDTH, default 1, number of independent single-bit channels (1..32).
REQ-002 SHALL have parameter STAGES, default 2, synchroniser flop depth per channel (2..4).
REQ-003 SHALL have parameter FILT_CNT, default 0, extra consecutive stable cycles required before output update (0..255; 0 = no filtering).
REQ-004 SHALL have parameter RST_VAL, default all-zero, WIDTH-bit reset value of the chain and data_out.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset; one clock, synchronous, active-low.
REQ-007 SHALL have port data_in  input  WIDTH  asynchronous level inputs.
REQ-008 SHALL have port data_out  output  WIDTH  synchronised, filtered levels (registered).
REQ-009 SHALL have port rise  output  WIDTH  one-cycle pulse per channel when data_out goes 0->1 (registered).
REQ-010 SHALL have port fall  output  WIDTH  one-cycle pulse per channel when data_out goes 1->0 (registered).
REQ-011 SHALL have port chg  output  1  OR-reduction of rise|fall (combinational from registers).

Function
REQ-012 SHALL implement per channel a chain stage[0..STAGES-1]: stage[0]<=data_in, stage[k]<=stage[k-1]; s = stage[STAGES-1].
REQ-013 SHALL keep per channel a counter cnt of width ceil(log2(FILT_CNT+1)), min 1 bit, and register filt driving data_out.
REQ-014 SHALL, each edge: if s==filt then cnt<=0; else if cnt==FILT_CNT then filt<=s, cnt<=0; else cnt<=cnt+1.
REQ-015 SHALL produce data_in->data_out latency of exactly STAGES+FILT_CNT+1 edges for a step held stable.
REQ-016 SHALL reject any excursion of s lasting <= FILT_CNT cycles (data_out unchanged, no pulse, cnt returns to 0).
REQ-017 SHALL assert rise[i] (fall[i]) in exactly the cycle data_out[i] first shows 1 (0), deasserting the next cycle.
REQ-018 SHALL never assert rise[i] and fall[i] together; channels SHALL operate fully independently, simultaneous changes on several bits allowed.
REQ-019 SHALL not saturate or wrap cnt: cnt never exceeds FILT_CNT.
REQ-020 SHALL, with FILT_CNT=0, update filt one edge after s differs (pure STAGES+1 synchroniser with edge pulses).

Reset
REQ-021 SHALL, on an edge with rst_n=0, load all stages and filt with RST_VAL, cnt with 0, rise/fall with 0.
REQ-022 SHALL generate no rise/fall pulse due to reset itself, including reset asserted mid-filtering or mid-pulse.
REQ-023 SHALL resume normal operation on the first edge with rst_n=1; a data_in differing from RST_VAL then propagates with REQ-015 latency.

Structure
REQ-024 SHALL place parameter limits (WIDTH_MAX=32, STAGES_MIN=2, STAGES_MAX=4, FILT_CNT_MAX=255) and a constant clog2 function in shared package sync_pkg.
REQ-025 SHALL implement one channel as sub-module sync_bit_filt (chain, counter, filt, rise, fall), instantiated WIDTH times by generate; top adds chg reduction only.
REQ-026 SHALL contain no combinational path from data_in to any output; no logic between chain stages.
REQ-027 SHALL flag out-of-range parameters at elaboration.

Verification
REQ-028 SHALL cover: WIDTH=1,STAGES=2,FILT_CNT=0, data_in 0->1 at edge 0 -> data_out=1 and rise=1 after edge 3, rise=0 after edge 4.
REQ-029 SHALL cover: STAGES=3,FILT_CNT=4, data_in high for 4 cycles then low -> data_out stays 0, no pulse; high for 5 cycles -> data_out=1 after edge 3+4+1=8.
REQ-030 SHALL cover: WIDTH=8, data_in 0x00->0xA5 in one cycle -> rise=0xA5 for one cycle, fall=0x00, chg=1 for exactly one cycle.
REQ-031 SHALL cover: RST_VAL=0xFF,WIDTH=8, rst_n low with data_in=0x00 -> data_out=0xFF, rise=fall=0; release -> fall=0xFF one cycle after STAGES+FILT_CNT+1 edges.
REQ-032 SHALL cover: rst_n asserted while cnt=FILT_CNT-1 (FILT_CNT=4) -> cnt=0, no pulse, data_out=RST_VAL on the next edge.
REQ-033 SHALL cover: randomised data_in with random glitch widths on WIDTH=4 -> output matches cycle-accurate reference model, rise/fall mutually exclusive.
